// File: rtl/regfile_writeback_pkg.sv
// Shared register-file geometry and the write-back queue entry type.
package regfile_pkg;

  localparam int NUM_REGS = 64;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Result sources, register-file write port and operand-check signals of the write-back front end.
interface regfile_writeback_if #(
  parameter int DEPTH = 4
);
  import regfile_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              wb_hold;
  logic              wrt;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] dataIn;
  logic [REG_AW-1:0] chk_rs1;
  logic [REG_AW-1:0] chk_rs2;
  logic              rs1_pending;
  logic              rs2_pending;
  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;
  logic [CW-1:0]     count;

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
           wb_hold, chk_rs1, chk_rs2,
    input  mem_ready, alu_ready, wrt, rd, dataIn,
           rs1_pending, rs2_pending, rs1_fwd, rs2_fwd, count
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
           wb_hold, chk_rs1, chk_rs2,
    output mem_ready, alu_ready, wrt, rd, dataIn,
           rs1_pending, rs2_pending, rs1_fwd, rs2_fwd, count
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// In-order circular buffer of write-back entries; exposes every slot with its valid bit
// and age (distance from head) so the top can pick the youngest match.
module wb_entry_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  wb_entry_t                  push_entry_i,
  input  logic                       pop_i,
  output wb_entry_t                  head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [CW-1:0]              count_o,
  output wb_entry_t [DEPTH-1:0]      entries_o,
  output logic [DEPTH-1:0]           valid_o,
  output logic [DEPTH-1:0][PW-1:0]   age_o
);

  wb_entry_t [DEPTH-1:0] ent_q;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pop_en, push_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A push into a full buffer is only legal when the head leaves on the same edge.
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);

  always_comb begin
    vld_d   = vld_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_en) - CW'(pop_en);
    if (pop_en) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    if (push_en) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) ent_q[wptr_q] <= push_entry_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) age_o[i] = PW'(i) - rptr_q;
  end

  assign head_o    = ent_q[rptr_q];
  assign count_o   = count_q;
  assign entries_o = ent_q;
  assign valid_o   = vld_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the 64x32 register file: arbitrates load/ALU results into an
// in-order queue, drains it one write per cycle, and forwards the youngest queued data.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b0
) (
  input logic               clk,
  input logic               rst,
  regfile_writeback_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t                 head;
  wb_entry_t                 push_entry;
  wb_entry_t [DEPTH-1:0]     entries;
  logic [DEPTH-1:0]          valid;
  logic [DEPTH-1:0][PW-1:0]  age;
  logic [CW-1:0]             count;
  logic                      empty, full;
  logic                      pop, space;
  logic                      mem_fire, alu_fire, drop, push;
  fwd_t                      fwd1, fwd2;

  function automatic fwd_t youngest_match(
    input logic [REG_AW-1:0]        rs,
    input wb_entry_t [DEPTH-1:0]    ents,
    input logic [DEPTH-1:0]         vld,
    input logic [DEPTH-1:0][PW-1:0] ages
  );
    fwd_t          r;
    logic [PW-1:0] best;
    r    = '0;
    best = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ents[i].rd == rs) && (!r.hit || (ages[i] > best))) begin
        r.hit  = 1'b1;
        r.data = ents[i].data;
        best   = ages[i];
      end
    end
    return r;
  endfunction

  assign pop   = ~empty & ~bus.wb_hold;
  assign space = ~full | pop;

  // Loads always win; the ALU only sees ready when no load is offered.
  assign bus.mem_ready = space & ~rst;
  assign bus.alu_ready = space & ~bus.mem_valid & ~rst;
  assign mem_fire      = bus.mem_valid & bus.mem_ready;
  assign alu_fire      = bus.alu_valid & bus.alu_ready;

  always_comb begin
    push_entry = '0;
    if (mem_fire) begin
      push_entry.rd   = bus.mem_rd;
      push_entry.data = bus.mem_data;
    end else if (alu_fire) begin
      push_entry.rd   = bus.alu_rd;
      push_entry.data = bus.alu_data;
    end
  end

  // r0 writes are acknowledged to the source but never reach the queue.
  assign drop = DROP_R0 && (push_entry.rd == '0);
  assign push = (mem_fire | alu_fire) & ~drop;

  wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop & ~rst),
    .head_o       (head),
    .empty_o      (empty),
    .full_o       (full),
    .count_o      (count),
    .entries_o    (entries),
    .valid_o      (valid),
    .age_o        (age)
  );

  assign fwd1 = youngest_match(bus.chk_rs1, entries, valid, age);
  assign fwd2 = youngest_match(bus.chk_rs2, entries, valid, age);

  assign bus.wrt         = pop & ~rst;
  assign bus.rd          = (empty || rst) ? '0 : head.rd;
  assign bus.dataIn      = (empty || rst) ? '0 : head.data;
  assign bus.rs1_pending = fwd1.hit & ~rst;
  assign bus.rs2_pending = fwd2.hit & ~rst;
  assign bus.rs1_fwd     = (fwd1.hit && !rst) ? fwd1.data : '0;
  assign bus.rs2_fwd     = (fwd2.hit && !rst) ? fwd2.data : '0;
  assign bus.count       = count;

endmodule
